// File: rtl/traffic_phase_scheduler_if.sv
// traffic_phase_scheduler_if: control inputs and lamp/state outputs of the scheduler; night_mode exists only with NIGHT_FLASH_EN
interface traffic_phase_scheduler_if;
  logic tick;
  logic car;
  logic ped_req;
`ifdef NIGHT_FLASH_EN
  logic night_mode;
`endif
  logic main_g;
  logic main_y;
  logic main_r;
  logic side_g;
  logic side_y;
  logic side_r;
  logic walk;
  logic [2:0] pres_state;
`ifdef NIGHT_FLASH_EN
  modport master (output tick, car, ped_req, night_mode,
                  input main_g, main_y, main_r, side_g, side_y, side_r, walk, pres_state);
  modport slave (input tick, car, ped_req, night_mode,
                 output main_g, main_y, main_r, side_g, side_y, side_r, walk, pres_state);
`else
  modport master (output tick, car, ped_req,
                  input main_g, main_y, main_r, side_g, side_y, side_r, walk, pres_state);
  modport slave (input tick, car, ped_req,
                 output main_g, main_y, main_r, side_g, side_y, side_r, walk, pres_state);
`endif
endinterface

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: tick-timed phase sequencer for main/side roads plus walk phase; optional NIGHT_FLASH_EN adds a flashing night mode
module traffic_phase_scheduler #(
  parameter int MIN_GREEN_MAIN = 8,
  parameter int SIDE_GREEN     = 5,
  parameter int YELLOW_TIME    = 2,
  parameter int ALL_RED_TIME   = 1,
  parameter int PED_TIME       = 4,
  parameter int TW             = 8
) (
  input logic clk,
  input logic reset,
  traffic_phase_scheduler_if.slave bus
);
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN_S = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    PED_WALK    = 3'd6,
    NIGHT_FLASH = 3'd7
  } state_t;
  state_t state, nxt;
  logic [TW-1:0] count, ncnt;
  logic ped, nped, phase, nphase;
  logic [6:0] lamps;
  function automatic logic [TW-1:0] load(input state_t s);
    case (s)
      MAIN_GREEN:              load = TW'(MIN_GREEN_MAIN - 1);
      MAIN_YELLOW, SIDE_YELLOW: load = TW'(YELLOW_TIME - 1);
      ALL_RED_1, ALL_RED_2:    load = TW'(ALL_RED_TIME - 1);
      SIDE_GREEN_S:            load = TW'(SIDE_GREEN - 1);
      PED_WALK:                load = TW'(PED_TIME - 1);
      default:                 load = '0;
    endcase
  endfunction
  // lamp order {main_g, main_y, main_r, side_g, side_y, side_r, walk}
  function automatic logic [6:0] decode(input state_t s, input logic ph);
    decode = {s == MAIN_GREEN,
              s == MAIN_YELLOW || (s == NIGHT_FLASH && ph),
              !(s == MAIN_GREEN || s == MAIN_YELLOW || s == NIGHT_FLASH),
              s == SIDE_GREEN_S,
              s == SIDE_YELLOW,
              s == NIGHT_FLASH ? ph : !(s == SIDE_GREEN_S || s == SIDE_YELLOW),
              s == PED_WALK};
  endfunction
  // next state, timer and pending-walk request; entering a state reloads its duration
  always_comb begin
    nxt = state;
    ncnt = count;
    nphase = phase;
    nped = ped | (bus.ped_req && state != PED_WALK);
    if (bus.tick) begin
`ifdef NIGHT_FLASH_EN
      if (state == MAIN_GREEN && bus.night_mode) begin
        nxt = NIGHT_FLASH;
        nphase = 1'b0;
      end else if (state == NIGHT_FLASH) begin
        nphase = ~phase;
        nxt = bus.night_mode ? NIGHT_FLASH : MAIN_GREEN;
      end else
`endif
      if (count != '0) ncnt = count - 1'b1;
      else begin
        case (state)
          MAIN_GREEN:   nxt = (bus.car || ped) ? MAIN_YELLOW : MAIN_GREEN;
          MAIN_YELLOW:  nxt = ALL_RED_1;
          ALL_RED_1:    nxt = ped ? PED_WALK : bus.car ? SIDE_GREEN_S : ALL_RED_2;
          PED_WALK:     nxt = bus.car ? SIDE_GREEN_S : ALL_RED_2;
          SIDE_GREEN_S: nxt = SIDE_YELLOW;
          SIDE_YELLOW:  nxt = ALL_RED_2;
          default:      nxt = MAIN_GREEN;
        endcase
      end
    end
    if (nxt != state) ncnt = load(nxt);
    if (nxt == PED_WALK && state != PED_WALK) nped = 1'b0;
  end
  // state register with lamps registered from the next state so they switch on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MAIN_GREEN;
      count <= TW'(MIN_GREEN_MAIN - 1);
      ped <= 1'b0;
      phase <= 1'b0;
      lamps <= 7'b1000010;
    end else begin
      state <= nxt;
      count <= ncnt;
      ped <= nped;
      phase <= nphase;
      lamps <= decode(nxt, nphase);
    end
  end
  assign {bus.main_g, bus.main_y, bus.main_r, bus.side_g, bus.side_y, bus.side_r, bus.walk} = lamps;
  assign bus.pres_state = state;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed checks of phase sequencing, pedestrian handling and reset
module tb_traffic_phase_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [6:0] lamp_tab [0:7];
  traffic_phase_scheduler_if bus();
  traffic_phase_scheduler dut (.clk(clk), .reset(reset), .bus(bus));
  wire [6:0] lamps = {bus.main_g, bus.main_y, bus.main_r, bus.side_g, bus.side_y, bus.side_r, bus.walk};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic expect_st(input string tag, input int code);
    chk({tag, " state"}, 32'(bus.pres_state), 32'(code));
    chk({tag, " lamps"}, 32'(lamps), 32'(lamp_tab[code]));
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) bus.tick = 1'b1;
      @(negedge clk) bus.tick = 1'b0;
    end
  endtask
  task automatic tick_ped();
    @(negedge clk) begin bus.tick = 1'b1; bus.ped_req = 1'b1; end
    @(negedge clk) begin bus.tick = 1'b0; bus.ped_req = 1'b0; end
  endtask
  initial begin
    lamp_tab[0] = 7'b1000010;
    lamp_tab[1] = 7'b0100010;
    lamp_tab[2] = 7'b0010010;
    lamp_tab[3] = 7'b0011000;
    lamp_tab[4] = 7'b0010100;
    lamp_tab[5] = 7'b0010010;
    lamp_tab[6] = 7'b0010011;
    lamp_tab[7] = 7'b0000000;
    bus.tick = 1'b0;
    bus.car = 1'b0;
    bus.ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
    bus.night_mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    expect_st("reset", 0);
    reset = 1'b1;
    bus.car = 1'b1;
    ticks(7);  expect_st("car t7", 0);
    ticks(1);  expect_st("car t8", 1);
    ticks(2);  expect_st("car t10", 2);
    ticks(1);  expect_st("car t11", 3);
    ticks(5);  expect_st("car t16", 4);
    ticks(2);  expect_st("car t18", 5);
    ticks(1);  expect_st("car t19", 0);
    ticks(13); expect_st("mid side green", 3);
    @(negedge clk) reset = 1'b0;
    #1 expect_st("async reset", 0);
    @(negedge clk) expect_st("reset held", 0);
    reset = 1'b1;
    bus.car = 1'b0;
    for (int i = 0; i < 50; i++) begin
      ticks(1);
      chk("idle main", 32'(bus.pres_state), 32'd0);
    end
    bus.car = 1'b1;
    ticks(1);  expect_st("late car", 1);
    ticks(3);  expect_st("to side", 3);
    repeat (100) @(negedge clk);
    expect_st("no tick", 3);
    ticks(5);  expect_st("idle sy", 4);
    ticks(3);  expect_st("back main", 0);
    bus.car = 1'b0;
    ticks(2);
    tick_ped();
    ticks(4);  expect_st("ped t7", 0);
    ticks(1);  expect_st("ped t8", 1);
    ticks(2);  expect_st("ped t10", 2);
    ticks(1);  expect_st("ped t11", 6);
    ticks(3);  expect_st("ped t14", 6);
    ticks(1);  expect_st("ped t15", 5);
    ticks(1);  expect_st("ped t16", 0);
    bus.car = 1'b1;
    @(negedge clk) bus.ped_req = 1'b1;
    @(negedge clk) bus.ped_req = 1'b0;
    ticks(10); expect_st("both t10", 2);
    tick_ped(); expect_st("both t11", 6);
    ticks(4);  expect_st("both t15", 3);
    ticks(5);  expect_st("both t20", 4);
    ticks(3);  expect_st("both t23", 0);
    bus.car = 1'b0;
    ticks(10); expect_st("ped cleared", 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    ticks(20); expect_st("t20 hold", 0);
    bus.car = 1'b1;
    ticks(1);  expect_st("t21", 1);
    ticks(2);  expect_st("t23", 2);
    bus.car = 1'b0;
    ticks(1);  expect_st("withdraw", 5);
    ticks(1);  expect_st("withdraw main", 0);
`ifdef NIGHT_FLASH_EN
    bus.night_mode = 1'b1;
    ticks(1);  expect_st("night enter", 7);
    ticks(1);  chk("night on", 32'(lamps), 32'(7'b0100010));
    ticks(1);  chk("night off", 32'(lamps), 32'(7'b0000000));
    bus.night_mode = 1'b0;
    ticks(1);  expect_st("night exit", 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Timed phase sequencer for a two-road intersection: main road and side road (with car sensor), plus a pedestrian walk phase.
- Owns the phase state machine and the per-phase tick counter.
- Drives both roads' green/yellow/red lamps and the walk lamp.
- Exports the present-state code for the seven-segment display manager.
- Time advances only on a one-cycle `tick` enable from the existing timebase.

Parameters:
- MIN_GREEN_MAIN, 8: minimum main-green duration, in ticks (>=1)
- SIDE_GREEN, 5: side-green duration, in ticks (>=1)
- YELLOW_TIME, 2: yellow duration for either road, in ticks (>=1)
- ALL_RED_TIME, 1: all-red clearance duration, in ticks (>=1)
- PED_TIME, 4: walk duration, in ticks (>=1)
- TW, 8: timer width; every duration must be <= 2^TW

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  timebase enable, one clk wide
- car  in  1  side-road car sensor, level, synchronous to clk
- ped_req  in  1  pedestrian request, pulse, synchronous
- main_g  out  1  main-road green lamp
- main_y  out  1  main-road yellow lamp
- main_r  out  1  main-road red lamp
- side_g  out  1  side-road green lamp
- side_y  out  1  side-road yellow lamp
- side_r  out  1  side-road red lamp
- walk  out  1  pedestrian walk lamp
- pres_state  out  3  present-state code, for the display manager

Behaviour:
States and codes:
- MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_2=5, PED_WALK=6.
- Code 7 is reserved for the optional feature.

Reset (reset=0, asynchronous):
- state=MAIN_GREEN, count=MIN_GREEN_MAIN-1, ped_pending=0.
- Outputs: main_g=1, side_r=1, all other lamps 0, pres_state=0.

Timer:
- On entry to a state, count loads that state's duration-1.
- On tick with count!=0: count decrements.
- On tick with count==0: the exit rule is evaluated.
- Without tick, nothing advances.

Exit rules (evaluated on tick with count==0):
- MAIN_GREEN: goes to MAIN_YELLOW if car=1 or ped_pending=1. Otherwise it stays, with count held at 0, so a later request exits on the next tick.
- MAIN_YELLOW goes to ALL_RED_1.
- ALL_RED_1:
  - ped_pending=1 goes to PED_WALK;
  - else car=1 goes to SIDE_GREEN;
  - else goes to ALL_RED_2 (car withdrew, return to main).
- PED_WALK: goes to SIDE_GREEN if car=1, else to ALL_RED_2.
- SIDE_GREEN goes to SIDE_YELLOW.
- SIDE_YELLOW goes to ALL_RED_2.
- ALL_RED_2 goes to MAIN_GREEN.

Pedestrian request:
- ped_pending sets on a cycle with ped_req=1.
- ped_pending clears on the cycle the FSM enters PED_WALK. Entry wins over a simultaneous ped_req.
- ped_req while in PED_WALK is ignored.
- ped_req in any other state is held until served.

Lamp decode (combinational from the registered state):
- MAIN_GREEN: main_g=1. MAIN_YELLOW: main_y=1. Main-road lamps are red (main_r=1) in all other states.
- SIDE_GREEN: side_g=1. SIDE_YELLOW: side_y=1. Side-road lamps are red (side_r=1) in all other states.
- walk=1 only in PED_WALK.
- Exactly one lamp per road is lit at all times.
- pres_state = state code.
- Lamps change on the clk edge that samples the qualifying tick. Latency from tick to lamp change is 1 clk.

Timing guarantee: green is never adjacent to green; every change of right-of-way passes through yellow then all-red.

Reset mid-phase: any state returns immediately to the reset values; a pending pedestrian request is lost.

Optional Feature:
NIGHT_FLASH_EN
- Defined:
  - Adds input `night_mode` (1 bit).
  - In MAIN_GREEN, a tick with night_mode=1 enters NIGHT_FLASH (code 7), regardless of count.
  - In NIGHT_FLASH, a phase bit toggles on every tick: main_y=phase, side_r=phase, all other lamps 0, walk=0, ped_pending held.
  - A tick with night_mode=0 goes to MAIN_GREEN with count reloaded.
- Undefined: no night_mode port; code 7 is unreachable.

Test Plan:
1. Reset low mid-SIDE_GREEN -> next cycle main_g=1, side_r=1, pres_state=0, walk=0. After release, with car=0 held for 50 ticks, the block stays in MAIN_GREEN.
2. Release reset, car=1 held -> MAIN_YELLOW after tick 8, ALL_RED_1 after tick 10, SIDE_GREEN after tick 11, SIDE_YELLOW after tick 16, ALL_RED_2 after tick 18, MAIN_GREEN after tick 19.
3. car=0 throughout, ped_req pulse at tick 3 -> MAIN_YELLOW after tick 8, PED_WALK (walk=1, side_r=1, main_r=1) after tick 11, ALL_RED_2 after tick 15, MAIN_GREEN after tick 16.
4. ped_req and car both asserted before tick 8 -> sequence ALL_RED_1, PED_WALK, SIDE_GREEN. ped_pending is 0 on the PED_WALK entry cycle, including when ped_req coincides with that cycle.
5. car=1 raised at tick 20 after reset, with MAIN_GREEN count already at 0 -> MAIN_YELLOW on tick 21. car dropped before ALL_RED_1 expires -> ALL_RED_2, then MAIN_GREEN.
6. tick held 0 for 100 clk in any state -> no state or lamp change. With NIGHT_FLASH_EN: night_mode=1 in MAIN_GREEN -> pres_state=7 with main_y/side_r toggling per tick; night_mode=0 -> MAIN_GREEN.
